sram_8blk_arbiter: RTL and testbench
====================================

Name: sram_8blk_arbiter

Overview:
- Sequences and shares the 8-block, 2048x20b coefficient SRAM between two requesters: a write/load port (precomputed-value loader) and a read port (FIR tap engine).
- Drives the SRAM's registered address/data/WEN/CEN pins, one access per cycle.
- Returns read data with a fixed latency and a tag.
- Fixed read priority, with an anti-starvation guarantee for writes.

Parameters:
- AW, 11, SRAM address width (AW-1:AW-3 block select, AW-4:0 word).
- DW, 20, SRAM data width.
- TW, 4, read tag width.
- READ_LAT, 2, cycles from grant to SRAM Q valid at this block's input.
- MAX_WAIT, 7, maximum consecutive cycles a pending write may lose to reads.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  AW  read address.
- rd_tag  in  TW  requester tag.
- rd_rvalid  out  1  read data valid.
- rd_rdata  out  DW  read data.
- rd_rtag  out  TW  tag of returned data.
- mem_A  out  AW  SRAM address.
- mem_D  out  DW  SRAM write data.
- mem_WEN  out  1  SRAM write enable, active low.
- mem_CEN  out  1  SRAM chip enable, active low.
- mem_Q  in  DW  SRAM read data.
- busy  out  1  read returns outstanding.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - mem_CEN=1, mem_WEN=1, mem_A=0, mem_D=0.
  - rd_rvalid=0, rd_rdata=0, rd_rtag=0, busy=0.
  - Starvation counter=0; return pipeline flushed.
- Handshake: a transfer occurs when valid && ready in the same cycle. ready is combinational from the grant decision; ready never depends on ready.
- Grant decision (same cycle):
  - Only rd_valid: grant read.
  - Only wr_valid: grant write.
  - Both asserted and wait_cnt < MAX_WAIT: grant read, wait_cnt += 1.
  - Both asserted and wait_cnt == MAX_WAIT: grant write.
  - wait_cnt clears on any write grant or whenever wr_valid=0. It saturates and never wraps.
  - Neither asserted: no grant.
- Issue (registered on the grant edge):
  - Read grant: mem_CEN=0, mem_WEN=1, mem_A=rd_addr. mem_D holds its previous value.
  - Write grant: mem_CEN=0, mem_WEN=0, mem_A=wr_addr, mem_D=wr_data.
  - No grant: mem_CEN=1, mem_WEN=1. A and D hold.
- Read return:
  - A READ_LAT-deep shift register carries {valid, tag} per issue cycle.
  - At the stage-READ_LAT output, rd_rvalid=1, rd_rdata=mem_Q (registered) and rd_rtag=tag.
  - Total latency: rd_valid&&rd_ready at cycle N gives rd_rvalid at cycle N+READ_LAT+1.
  - Returns come back in issue order, with no backpressure on returns.
- busy=1 while any pipeline stage holds valid.
- Throughput: one access per cycle. Back-to-back reads give back-to-back rd_rvalid.
- Hazards:
  - Read-after-write to the same address is ordered by issue order; the SRAM returns the new data.
  - No forwarding inside this block.
- rst mid-operation: the pipeline is flushed and in-flight returns are dropped; no rd_rvalid occurs after rst. mem_CEN is deasserted on the next edge.
- Addresses pass through unchanged. Block decode stays inside the SRAM wrapper.

Decomposition:
- Shared package sram_pkg: SRAM_AW=11, SRAM_DW=20, MEM_ON=1'b0, MEM_OFF=1'b1, and the grant encoding typedef {GNT_NONE, GNT_RD, GNT_WR}.
- One natural sub-module: sram_rd_return_pipe, the parameterised {valid, tag, data} delay line.

Test Plan:
- Reset hold: hold rst 3 cycles with both requests valid -> mem_CEN=1, mem_WEN=1, rd_rvalid=0 throughout, and wr_ready=rd_ready=0 while rst=1.
- Single write: write 0x5A5A5 to addr 0x3FF -> next edge mem_CEN=0, mem_WEN=0, mem_A=0x3FF, mem_D=0x5A5A5; then CEN returns to 1.
- Read latency: read addr 0x101 with tag 0x3, SRAM model returning 0x12345 -> rd_rvalid exactly READ_LAT+1 cycles later with rdata=0x12345, rtag=0x3.
- Starvation: rd_valid and wr_valid both held -> 7 read grants, then 1 write grant (wr_ready=1), repeating 7:1. Tags stay in order.
- Write-then-read same address: write 0x000AB at addr 0x7FE at cycle N, read 0x7FE at N+1 -> returned data 0x000AB.
- Reset mid-flight: issue 2 reads, assert rst the next cycle -> no rd_rvalid, busy=0 after reset.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM constants and grant encoding
package sram_pkg;

   localparam int   SRAM_AW = 11;
   localparam int   SRAM_DW = 20;

   // SRAM control pins are active low
   localparam logic MEM_ON  = 1'b0;
   localparam logic MEM_OFF = 1'b1;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_RD   = 2'd1,
      GNT_WR   = 2'd2
   } gnt_e;

endpackage

// File: rtl/sram_rd_return_pipe.sv
// rtl/sram_rd_return_pipe.sv - {valid, tag} delay line with registered SRAM data capture
module sram_rd_return_pipe #(
   parameter int DW  = 20,
   parameter int TW  = 4,
   parameter int LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   input  logic [TW-1:0] i_tag,
   input  logic [DW-1:0] i_q,
   output logic          o_rvalid,
   output logic [DW-1:0] o_rdata,
   output logic [TW-1:0] o_rtag,
   output logic          o_busy
);

   logic [LAT-1:0] r_vld;
   logic [TW-1:0]  r_tag [LAT];
   logic           r_rvalid;
   logic [DW-1:0]  r_rdata;
   logic [TW-1:0]  r_rtag;

   // Shift {valid, tag} one stage per cycle; reset drops everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
      end else begin
         r_vld[0] <= i_valid;
         r_tag[0] <= i_tag;
         for (int i = 1; i < LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   // Capture SRAM Q when the last stage says it belongs to an issued read
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rtag   <= '0;
      end else begin
         r_rvalid <= r_vld[LAT-1];
         if (r_vld[LAT-1]) begin
            r_rdata <= i_q;
            r_rtag  <= r_tag[LAT-1];
         end
      end
   end

   assign o_rvalid = r_rvalid;
   assign o_rdata  = r_rdata;
   assign o_rtag   = r_rtag;
   assign o_busy   = |r_vld;

endmodule

// File: rtl/sram_8blk_arbiter.sv
// rtl/sram_8blk_arbiter.sv - read-priority SRAM port arbiter with write anti-starvation
module sram_8blk_arbiter
   import sram_pkg::*;
#(
   parameter int AW       = SRAM_AW,
   parameter int DW       = SRAM_DW,
   parameter int TW       = 4,
   parameter int READ_LAT = 2,
   parameter int MAX_WAIT = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_valid,
   output logic          rd_ready,
   input  logic [AW-1:0] rd_addr,
   input  logic [TW-1:0] rd_tag,
   output logic          rd_rvalid,
   output logic [DW-1:0] rd_rdata,
   output logic [TW-1:0] rd_rtag,
   output logic [AW-1:0] mem_A,
   output logic [DW-1:0] mem_D,
   output logic          mem_WEN,
   output logic          mem_CEN,
   input  logic [DW-1:0] mem_Q,
   output logic          busy
);

   // One spare bit keeps the width non-zero and leaves headroom above MAX_WAIT
   localparam int             WCW   = $clog2(MAX_WAIT + 2);
   localparam logic [WCW-1:0] MAX_W = WCW'(MAX_WAIT);

   gnt_e           w_gnt;
   logic [WCW-1:0] w_wait_nxt;
   logic [WCW-1:0] r_wait_cnt;
   logic           r_mem_cen;
   logic           r_mem_wen;
   logic [AW-1:0]  r_mem_a;
   logic [DW-1:0]  r_mem_d;

   // Grant decision: reads win until a pending write has lost MAX_WAIT times in a row
   always_comb begin
      w_gnt      = GNT_NONE;
      w_wait_nxt = '0;
      if (rst) begin
         w_gnt      = GNT_NONE;
         w_wait_nxt = '0;
      end else if (rd_valid && wr_valid) begin
         if (r_wait_cnt >= MAX_W) begin
            w_gnt      = GNT_WR;
            w_wait_nxt = '0;
         end else begin
            w_gnt      = GNT_RD;
            w_wait_nxt = r_wait_cnt + 1'b1;
         end
      end else if (rd_valid) begin
         w_gnt = GNT_RD;
      end else if (wr_valid) begin
         w_gnt = GNT_WR;
      end
   end

   // Starvation counter: counts consecutive reads granted over a pending write
   always_ff @(posedge clk) begin
      if (rst) r_wait_cnt <= '0;
      else     r_wait_cnt <= w_wait_nxt;
   end

   // Register the SRAM pins on the grant edge; A and D hold when not reloaded
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_cen <= MEM_OFF;
         r_mem_wen <= MEM_OFF;
         r_mem_a   <= '0;
         r_mem_d   <= '0;
      end else begin
         case (w_gnt)
            GNT_RD: begin
               r_mem_cen <= MEM_ON;
               r_mem_wen <= MEM_OFF;
               r_mem_a   <= rd_addr;
            end
            GNT_WR: begin
               r_mem_cen <= MEM_ON;
               r_mem_wen <= MEM_ON;
               r_mem_a   <= wr_addr;
               r_mem_d   <= wr_data;
            end
            default: begin
               r_mem_cen <= MEM_OFF;
               r_mem_wen <= MEM_OFF;
            end
         endcase
      end
   end

   assign rd_ready = (w_gnt == GNT_RD);
   assign wr_ready = (w_gnt == GNT_WR);
   assign mem_CEN  = r_mem_cen;
   assign mem_WEN  = r_mem_wen;
   assign mem_A    = r_mem_a;
   assign mem_D    = r_mem_d;

   sram_rd_return_pipe #(
      .DW  (DW),
      .TW  (TW),
      .LAT (READ_LAT)
   ) u_ret (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (w_gnt == GNT_RD),
      .i_tag    (rd_tag),
      .i_q      (mem_Q),
      .o_rvalid (rd_rvalid),
      .o_rdata  (rd_rdata),
      .o_rtag   (rd_rtag),
      .o_busy   (busy)
   );

endmodule

// File: tb/tb_sram_8blk_arbiter.sv
// tb/tb_sram_8blk_arbiter.sv - directed vector bench for sram_8blk_arbiter
module tb_sram_8blk_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid, wr_ready, rd_valid, rd_ready;
   logic [10:0] wr_addr, rd_addr, mem_A;
   logic [19:0] wr_data, rd_rdata, mem_D, mem_Q;
   logic [3:0]  rd_tag, rd_rtag;
   logic        rd_rvalid, mem_WEN, mem_CEN, busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic        rv, wv;
      logic [10:0] ra;
      logic [3:0]  rt;
      logic [10:0] wa;
      logic [19:0] wd;
      logic        e_rr, e_wr, e_cen, e_wen;
      logic [10:0] e_a;
      logic [19:0] e_d;
      logic [19:0] e_q;
   } vec_t;

   typedef struct {
      int          due;
      logic [3:0]  tag;
      logic [19:0] data;
   } ret_t;

   vec_t tv [28];
   ret_t exp_q [$];
   logic [19:0] sram [2048];

   sram_8blk_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_addr   (rd_addr),
      .rd_tag    (rd_tag),
      .rd_rvalid (rd_rvalid),
      .rd_rdata  (rd_rdata),
      .rd_rtag   (rd_rtag),
      .mem_A     (mem_A),
      .mem_D     (mem_D),
      .mem_WEN   (mem_WEN),
      .mem_CEN   (mem_CEN),
      .mem_Q     (mem_Q),
      .busy      (busy)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to time expected read returns
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous SRAM model: pins sampled at the edge, Q valid the cycle after
   always @(posedge clk) begin
      if (mem_CEN == 1'b0) begin
         if (mem_WEN == 1'b0) sram[mem_A] <= mem_D;
         else                 mem_Q <= sram[mem_A];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rv, input logic wv, input logic [10:0] ra,
                               input logic [3:0] rt, input logic [10:0] wa, input logic [19:0] wd,
                               input logic e_rr, input logic e_wr, input logic e_cen,
                               input logic e_wen, input logic [10:0] e_a, input logic [19:0] e_d,
                               input logic [19:0] e_q);
      vec_t v;
      v.rv = rv; v.wv = wv; v.ra = ra; v.rt = rt; v.wa = wa; v.wd = wd;
      v.e_rr = e_rr; v.e_wr = e_wr; v.e_cen = e_cen; v.e_wen = e_wen;
      v.e_a = e_a; v.e_d = e_d; v.e_q = e_q;
      return v;
   endfunction

   // Return monitor: rd_rvalid must be high exactly on each expected due cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         chk("rvalid", 32'(rd_rvalid), 32'd1);
         chk("rdata", 32'(rd_rdata), 32'(exp_q[0].data));
         chk("rtag", 32'(rd_rtag), 32'(exp_q[0].tag));
         void'(exp_q.pop_front());
      end else begin
         chk("rvalid_idle", 32'(rd_rvalid), 32'd0);
      end
      if (rst) exp_q.delete();
   end

   initial begin
      ret_t r;
      rst = 1'b1;
      rd_valid = 1'b1; wr_valid = 1'b1;
      rd_addr = 11'h055; rd_tag = 4'h7; wr_addr = 11'h066; wr_data = 20'h0F0F0;

      tv[0] = mk(0, 1, 0, 0, 11'h3FF, 20'h5A5A5, 0, 1, 0, 0, 11'h3FF, 20'h5A5A5, 0);
      tv[1] = mk(0, 0, 0, 0, 0, 0,                0, 0, 1, 1, 11'h3FF, 20'h5A5A5, 0);
      tv[2] = mk(0, 1, 0, 0, 11'h101, 20'h12345, 0, 1, 0, 0, 11'h101, 20'h12345, 0);
      tv[3] = mk(1, 0, 11'h101, 4'h3, 0, 0,      1, 0, 0, 1, 11'h101, 20'h12345, 20'h12345);
      for (int k = 4; k < 7; k++)
         tv[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 11'h101, 20'h12345, 0);
      for (int i = 0; i < 16; i++) begin
         logic is_wr;
         is_wr = ((i % 8) == 7);
         tv[7+i] = mk(1, 1, 11'h3FF, 4'(i - i / 8), 11'h200,
                      (i < 8) ? 20'h11111 : 20'h22222,
                      !is_wr, is_wr, 0, !is_wr,
                      is_wr ? 11'h200 : 11'h3FF,
                      (i < 7) ? 20'h12345 : ((i < 15) ? 20'h11111 : 20'h22222),
                      20'h5A5A5);
      end
      tv[23] = mk(0, 1, 0, 0, 11'h7FE, 20'h000AB, 0, 1, 0, 0, 11'h7FE, 20'h000AB, 0);
      tv[24] = mk(1, 0, 11'h7FE, 4'hA, 0, 0,     1, 0, 0, 1, 11'h7FE, 20'h000AB, 20'h000AB);
      for (int k = 25; k < 28; k++)
         tv[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 11'h7FE, 20'h000AB, 0);

      // Reset hold with both requests asserted
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_cen", 32'(mem_CEN), 32'd1);
         chk("rst_wen", 32'(mem_WEN), 32'd1);
         chk("rst_rvalid", 32'(rd_rvalid), 32'd0);
         chk("rst_wr_ready", 32'(wr_ready), 32'd0);
         chk("rst_rd_ready", 32'(rd_ready), 32'd0);
      end
      chk("rst_a", 32'(mem_A), 32'd0);
      chk("rst_d", 32'(mem_D), 32'd0);
      chk("rst_rdata", 32'(rd_rdata), 32'd0);
      chk("rst_rtag", 32'(rd_rtag), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;

      // Table-driven vectors: readies checked before the edge, pins after it
      for (int k = 0; k < 28; k++) begin
         rd_valid = tv[k].rv; wr_valid = tv[k].wv;
         rd_addr  = tv[k].ra; rd_tag   = tv[k].rt;
         wr_addr  = tv[k].wa; wr_data  = tv[k].wd;
         #1;
         chk($sformatf("v%0d_rd_ready", k), 32'(rd_ready), 32'(tv[k].e_rr));
         chk($sformatf("v%0d_wr_ready", k), 32'(wr_ready), 32'(tv[k].e_wr));
         if (tv[k].e_rr) begin
            r.due = cyc + 3; r.tag = tv[k].rt; r.data = tv[k].e_q;
            exp_q.push_back(r);
         end
         @(posedge clk); #1;
         chk($sformatf("v%0d_cen", k), 32'(mem_CEN), 32'(tv[k].e_cen));
         chk($sformatf("v%0d_wen", k), 32'(mem_WEN), 32'(tv[k].e_wen));
         chk($sformatf("v%0d_a", k), 32'(mem_A), 32'(tv[k].e_a));
         chk($sformatf("v%0d_d", k), 32'(mem_D), 32'(tv[k].e_d));
      end
      rd_valid = 1'b0; wr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-flight: two reads issued, reset before either returns
      rd_valid = 1'b1; rd_addr = 11'h101; rd_tag = 4'h1;
      #1;
      chk("mf_rd_ready0", 32'(rd_ready), 32'd1);
      r.due = cyc + 3; r.tag = 4'h1; r.data = 20'h12345; exp_q.push_back(r);
      @(posedge clk); #1;
      chk("mf_busy", 32'(busy), 32'd1);
      rd_addr = 11'h3FF; rd_tag = 4'h2;
      #1;
      chk("mf_rd_ready1", 32'(rd_ready), 32'd1);
      r.due = cyc + 3; r.tag = 4'h2; r.data = 20'h5A5A5; exp_q.push_back(r);
      @(posedge clk); #1;
      rd_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      chk("mf_busy_after", 32'(busy), 32'd0);
      chk("mf_cen_after", 32'(mem_CEN), 32'd1);
      chk("mf_rvalid_after", 32'(rd_rvalid), 32'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("returns_pending", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
